// File: rtl/spi_dac_pkg.sv
// Shared types and defaults for the SPI DAC transmitter.
package spi_dac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_e;

   localparam int unsigned DEF_DATA_WIDTH = 12;
   localparam int unsigned DEF_CMD_WIDTH  = 4;
   localparam int unsigned DEF_CLK_DIV    = 11;
   localparam int unsigned DEF_CS_SETUP   = 2;
   localparam int unsigned DEF_CS_HOLD    = 2;
   localparam int unsigned DEF_CS_GAP     = 2;

   function automatic int unsigned frame_w(input int unsigned cmd_w, input int unsigned data_w);
      return cmd_w + data_w;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_tx_baud.sv
// Half-period counter for the serial clock; flags the edge at which sck rises or falls.
module spi_tx_baud #(
   parameter int unsigned CLK_DIV = 11
) (
   input  logic clk,
   input  logic n_rst,
   input  logic en_i,
   input  logic sck_i,
   output logic rise_c_o,
   output logic fall_c_o
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             term_c;

   always_ff @(posedge clk) begin
      if (!n_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Counter is held at zero outside SHIFT so every frame starts on a full phase
   always_comb begin
      term_c = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
      cnt_d  = '0;
      if (en_i && !term_c) cnt_d = cnt_q + CNT_W'(1);
   end

   assign rise_c_o = term_c & ~sck_i;
   assign fall_c_o = term_c &  sck_i;

endmodule

// File: rtl/spi_dac_tx.sv
// SPI (mode 0) DAC frame transmitter: sends {cmd,data} MSB first under cs framing.
// Define SPI_DAC_TX_LDAC_EN to add the active-low ldac strobe after each frame.
module spi_dac_tx
   import spi_dac_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CMD_WIDTH  = DEF_CMD_WIDTH,
   parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
   parameter int unsigned CS_SETUP   = DEF_CS_SETUP,
   parameter int unsigned CS_HOLD    = DEF_CS_HOLD,
   parameter int unsigned CS_GAP     = DEF_CS_GAP
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  tx_en,
   input  logic [CMD_WIDTH-1:0]  cmd,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  busy,
   output logic                  done,
   output logic                  cs,
   output logic                  sck,
   output logic                  dout
`ifdef SPI_DAC_TX_LDAC_EN
  ,output logic                  ldac
`endif
);

   localparam int unsigned FRAME   = frame_w(CMD_WIDTH, DATA_WIDTH);
   localparam int unsigned SETUP_N = max_u(CS_SETUP, 1);
   localparam int unsigned HOLD_N  = max_u(CS_HOLD, 1);
   // GAP state length; the idle cycle that samples tx_en closes the cs-high window
`ifdef SPI_DAC_TX_LDAC_EN
   localparam int unsigned GAP_N   = max_u(CS_GAP, 3);
`else
   localparam int unsigned GAP_N   = max_u(CS_GAP, 2) - 1;
`endif
   localparam int unsigned CYC_MAX = max_u(max_u(SETUP_N, HOLD_N), GAP_N);
   localparam int unsigned CYC_W   = $clog2(CYC_MAX) + 1;
   localparam int unsigned BIT_W   = $clog2(FRAME) + 1;

   state_e             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [FRAME-1:0]   sh_q, sh_d;
   logic               sck_q, sck_d;
   logic               cs_q, cs_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               rise_c, fall_c;
`ifdef SPI_DAC_TX_LDAC_EN
   logic               ldac_q, ldac_d;
`endif

   spi_tx_baud #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk      (clk),
      .n_rst    (n_rst),
      .en_i     (state_q == SHIFT),
      .sck_i    (sck_q),
      .rise_c_o (rise_c),
      .fall_c_o (fall_c)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SPI_DAC_TX_LDAC_EN
         ldac_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SPI_DAC_TX_LDAC_EN
         ldac_q  <= ldac_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SPI_DAC_TX_LDAC_EN
      // Low for the two cycles following the done cycle
      ldac_d  = !((state_q == GAP) && (cyc_q < CYC_W'(2)));
`endif

      unique case (state_q)
         IDLE: begin
            if (tx_en) begin
               sh_d    = {cmd, data};
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               cyc_d   = '0;
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cyc_q == CYC_W'(SETUP_N - 1)) begin
               cyc_d   = '0;
               state_d = SHIFT;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         SHIFT: begin
            if (rise_c) begin
               sck_d = 1'b1;
               bit_d = bit_q + BIT_W'(1);
            end else if (fall_c) begin
               sck_d = 1'b0;
               // The last fall ends the shift; dout keeps the LSB through HOLD
               if (bit_q == BIT_W'(FRAME)) begin
                  cyc_d   = '0;
                  state_d = HOLD;
               end else begin
                  sh_d = {sh_q[FRAME-2:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (cyc_q == CYC_W'(HOLD_N - 1)) begin
               cs_d    = 1'b1;
               done_d  = 1'b1;
               sh_d    = '0;
               bit_d   = '0;
               cyc_d   = '0;
               state_d = GAP;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         GAP: begin
            if (cyc_q == CYC_W'(GAP_N - 1)) begin
               busy_d  = 1'b0;
               cyc_d   = '0;
               state_d = IDLE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign cs   = cs_q;
   assign sck  = sck_q;
   assign dout = sh_q[FRAME-1];
`ifdef SPI_DAC_TX_LDAC_EN
   assign ldac = ldac_q;
`endif

endmodule

// File: tb/tb_spi_dac_tx.sv
// Randomized bench for spi_dac_tx: two instances (CLK_DIV 11 and 1) against a cycle-offset reference model.
module tb_spi_dac_tx;

   localparam int F   = 16;
   localparam int SU  = 2;
   localparam int HO  = 2;
   localparam int CSG = 2;
`ifdef SPI_DAC_TX_LDAC_EN
   localparam int G   = ((CSG > 3) ? CSG : 3) + 1;
`else
   localparam int G   = CSG;
`endif
   localparam int L0  = SU + 2 * F * 11 + HO;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        tx_en;
   logic [3:0]  cmd;
   logic [11:0] data;
   logic [1:0]  busy, done, cs, sck, dout, ldac;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spi_dac_tx #(.CLK_DIV(11)) u_dut0 (
      .clk(clk), .n_rst(n_rst), .tx_en(tx_en), .cmd(cmd), .data(data),
      .busy(busy[0]), .done(done[0]), .cs(cs[0]), .sck(sck[0]), .dout(dout[0])
`ifdef SPI_DAC_TX_LDAC_EN
     ,.ldac(ldac[0])
`endif
   );

   spi_dac_tx #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .tx_en(tx_en), .cmd(cmd), .data(data),
      .busy(busy[1]), .done(done[1]), .cs(cs[1]), .sck(sck[1]), .dout(dout[1])
`ifdef SPI_DAC_TX_LDAC_EN
     ,.ldac(ldac[1])
`endif
   );

`ifndef SPI_DAC_TX_LDAC_EN
   assign ldac = 2'b11;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int frame_len(input int d);
      return SU + 2 * F * d + HO;
   endfunction

   // Expected {ldac,busy,done,cs,sck,dout} tt cycles after the capture edge (0 = idle)
   function automatic logic [5:0] exp_pins(input int tt, input logic [15:0] fr, input int d);
      int   l, ph;
      logic ld, bs, dn, c, s, o;
      l  = frame_len(d);
      ld = 1'b1; bs = 1'b0; dn = 1'b0; c = 1'b1; s = 1'b0; o = 1'b0;
      if (tt != 0 && tt < l + G) begin
         bs = 1'b1;
         if (tt <= l) begin
            c = 1'b0;
            if (tt <= SU) o = fr[F-1];
            else if (tt <= SU + 2 * F * d) begin
               ph = (tt - SU - 1) / d;
               s  = ph[0];
               o  = fr[F - 1 - ph / 2];
            end else o = fr[0];
         end else begin
            dn = (tt == l + 1);
`ifdef SPI_DAC_TX_LDAC_EN
            ld = !(tt == l + 2 || tt == l + 3);
`endif
         end
      end
      return {ld, bs, dn, c, s, o};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int D = (g == 0) ? 11 : 1;
      int          t = 0;
      logic [15:0] fr = '0;
      logic [15:0] word = '0;
      int          rises = 0, nframes = 0, lowcnt = 0, hicnt = 0, last_hi = 0;
      bit          inframe = 0, prev_cs = 1, prev_sck = 0, prev_dout = 0, rst_edge = 0;

      always @(posedge clk) begin
         rst_edge = !n_rst;
         if (rst_edge) t = 0;
         else if ((t == 0 || t >= frame_len(D) + G) && tx_en) begin
            t  = 1;
            fr = {cmd, data};
         end else if (t != 0 && t < frame_len(D) + G) t++;
         #1;
         check($sformatf("pins%0d_t%0d", g, t),
               32'({ldac[g], busy[g], done[g], cs[g], sck[g], dout[g]}),
               32'(exp_pins(t, fr, D)));
         if (rst_edge) begin
            inframe = 0; word = '0; rises = 0; lowcnt = 0; hicnt = 0;
         end else if (!cs[g]) begin
            if (prev_cs) begin
               inframe = 1; word = '0; rises = 0; lowcnt = 0; last_hi = hicnt;
            end
            lowcnt++;
            if (sck[g] && !prev_sck) begin
               check($sformatf("dout_stable%0d", g), 32'(dout[g]), 32'(prev_dout));
               word = {word[14:0], dout[g]};
               rises++;
            end
         end else begin
            if (!prev_cs && inframe) begin
               check($sformatf("frame_word%0d", g), 32'(word), 32'(fr));
               check($sformatf("cs_low_len%0d", g), 32'(lowcnt), 32'(frame_len(D)));
               check($sformatf("sck_rises%0d", g), 32'(rises), 32'(F));
               nframes++;
               inframe = 0;
               hicnt = 0;
            end
            hicnt++;
         end
         prev_cs = cs[g]; prev_sck = sck[g]; prev_dout = dout[g];
      end
   end

   task automatic send(input logic [3:0] c, input logic [11:0] d);
      @(negedge clk);
      cmd = c; data = d; tx_en = 1'b1;
      @(negedge clk);
      tx_en = 1'b0;
   endtask

   int f0;
   int k;

   initial begin
      n_rst = 1'b0; tx_en = 1'b0; cmd = '0; data = '0;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // Single default frame
      f0 = g_mon[0].nframes;
      send(4'h3, 12'hA5C);
      repeat (L0 + G + 5) @(negedge clk);
      check("a5c_frames", 32'(g_mon[0].nframes - f0), 32'd1);

      // All-ones frame, exercised at CLK_DIV=1 on the second instance
      f0 = g_mon[1].nframes;
      send(4'h0, 12'hFFF);
      repeat (L0 + G + 5) @(negedge clk);
      check("fff_frames_div1", 32'(g_mon[1].nframes - f0), 32'd1);

      // tx_en held for exactly three captures with inputs churning
      f0 = g_mon[0].nframes;
      @(negedge clk);
      tx_en = 1'b1;
      for (int i = 0; i < 2 * (L0 + G) + 1; i++) begin
         @(negedge clk);
         cmd  = 4'($urandom);
         data = 12'($urandom);
      end
      tx_en = 1'b0;
      repeat (L0 + G + 5) @(negedge clk);
      check("held_frames", 32'(g_mon[0].nframes - f0), 32'd3);
      check("cs_gap", 32'(g_mon[0].last_hi), 32'(G));

      // tx_en pulsed in HOLD and in the done cycle must be ignored
      f0 = g_mon[0].nframes;
      send(4'($urandom), 12'($urandom));
      repeat (L0 - 1) @(negedge clk);
      tx_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tx_en = 1'b0;
      repeat (L0 + G + 5) @(negedge clk);
      check("ignored_pulses", 32'(g_mon[0].nframes - f0), 32'd1);

      // Reset after the 7th rise, then a clean frame
      f0 = g_mon[0].nframes;
      send(4'($urandom), 12'($urandom));
      k = 0;
      while (g_mon[0].rises != 7 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("rise7_reached", 32'(g_mon[0].rises), 32'd7);
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      check("abort_no_frame", 32'(g_mon[0].nframes - f0), 32'd0);
      send(4'h1, 12'h234);
      repeat (L0 + G + 5) @(negedge clk);
      check("post_reset_frames", 32'(g_mon[0].nframes - f0), 32'd1);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cmd   = 4'($urandom);
         data  = 12'($urandom);
         tx_en = ($urandom_range(0, 39) == 0);
         n_rst = ($urandom_range(0, 499) != 0);
      end
      n_rst = 1'b1;
      tx_en = 1'b0;
      repeat (L0 + G + 5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
